credit_rr_output_allocator: RTL and testbench

- Per-output-port allocator for the credit-based router. Sits between the five input FIFOs (N, E, W, S, L) and one output link.
- Arbitrates round-robin among input FIFOs whose head flit routes to this output, and locks the output to the winner for a whole wormhole packet.
- Issues the one-hot read enable that pops the winning FIFO.
- Tracks downstream buffer space with a credit counter, so a flit is forwarded only when the downstream FIFO has a free slot.

---
 rtl/credit_rr_output_allocator.sv | 123 ++++++++++++
 tb/tb_credit_rr_output_allocator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/credit_rr_output_allocator.sv
// Per-output allocator: round-robin arbitration, wormhole lock per packet,
// and a downstream credit counter that gates each forwarded flit.
module credit_rr_output_allocator #(
    parameter int NUM_REQ      = 5,
    parameter int CREDIT_WIDTH = 2,
    parameter int INIT_CREDITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      tail,
    input  logic                    credit_in,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    valid_out,
    output logic [2:0]              sel,
    output logic [CREDIT_WIDTH-1:0] credit_cnt,
    output logic                    credit_err
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(INIT_CREDITS);
    localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);

    logic [0:0]              state_q, state_d;
    logic [2:0]              owner_q, owner_d;
    logic [2:0]              last_q, last_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic                    err_q, err_d;

    logic [2:0] winner;
    logic       found;
    logic       granted;
    logic       tail_hit;

    // Scan upward from the slot after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        winner = 3'd0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    always_comb begin
        grant    = '0;
        tail_hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state_q == LOCKED && owner_q == 3'(i)) begin
                grant[i] = req[i] & (credit_q != '0);
                tail_hit = tail[i];
            end
        end
    end

    assign granted    = |grant;
    assign valid_out  = granted;
    assign sel        = (state_q == LOCKED) ? owner_q : 3'd0;
    assign credit_cnt = credit_q;
    assign credit_err = err_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (granted && tail_hit) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturate at the initial credit count; an extra return is a protocol error.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (credit_in && !granted) begin
            if (credit_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end else if (!credit_in && granted) begin
            credit_d = credit_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 3'd0;
            last_q   <= LAST_RST;
            credit_q <= CRED_MAX;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_credit_rr_output_allocator.sv
// Scoreboard bench: a behavioural model predicts outputs per cycle,
// a separate monitor pops and compares on the falling edge.
module tb_credit_rr_output_allocator;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         credit_in;
    logic [N-1:0] grant;
    logic         valid_out;
    logic [2:0]   sel;
    logic [1:0]   credit_cnt;
    logic         credit_err;

    typedef struct {
        logic [N-1:0] grant;
        logic         valid;
        logic [2:0]   sel;
        logic [1:0]   cnt;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    bit m_locked;
    int m_owner;
    int m_last;
    int m_cred;
    bit m_err;

    credit_rr_output_allocator dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .grant      (grant),
        .valid_out  (valid_out),
        .sel        (sel),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    function automatic bit m_granted(logic [N-1:0] r);
        return m_locked && r[m_owner] && (m_cred > 0);
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_last   = N - 1;
        m_cred   = 3;
        m_err    = 0;
    endtask

    task automatic model_step(logic r, logic [N-1:0] q, logic [N-1:0] t,
                              logic c);
        bit g;
        if (r) begin
            model_reset();
            return;
        end
        g = m_granted(q);
        if (c && !g) begin
            if (m_cred == 3) m_err = 1;
            else m_cred++;
        end else if (!c && g) begin
            m_cred--;
        end
        if (!m_locked) begin
            if (q != 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (q[(m_last + k) % N]) begin
                        m_owner  = (m_last + k) % N;
                        m_locked = 1;
                        break;
                    end
                end
            end
        end else if (g && t[m_owner]) begin
            m_locked = 0;
            m_last   = m_owner;
        end
    endtask

    // Drive one cycle of inputs, queue the prediction, advance the model.
    task automatic step(logic r, logic [N-1:0] q, logic [N-1:0] t, logic c);
        exp_t e;
        reset     = r;
        req       = q;
        tail      = t;
        credit_in = c;
        e.grant = m_granted(q) ? (N'(1) << m_owner) : '0;
        e.valid = m_granted(q);
        e.sel   = m_locked ? 3'(m_owner) : 3'd0;
        e.cnt   = 2'(m_cred);
        e.err   = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        model_step(r, q, t, c);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant || valid_out !== e.valid || sel !== e.sel ||
                credit_cnt !== e.cnt || credit_err !== e.err) begin
                n_bad++;
                $display("FAIL cycle@%0t: got g=%b v=%b s=%0d c=%0d e=%b exp g=%b v=%b s=%0d c=%0d e=%b",
                         $time, grant, valid_out, sel, credit_cnt, credit_err,
                         e.grant, e.valid, e.sel, e.cnt, e.err);
            end
        end
    end

    initial begin
        reset = 1; req = '0; tail = '0; credit_in = 0;
        @(posedge clk);
        model_reset();
        #1;
        // single port packet draining credits, tail stalls until a credit
        step(0, 5'b00001, 5'b00000, 0);
        repeat (3) step(0, 5'b00001, 5'b00000, 0);
        step(0, 5'b00001, 5'b00001, 0);
        step(0, 5'b00001, 5'b00001, 1);
        step(0, 5'b00001, 5'b00001, 0);
        step(0, 5'b00000, 5'b00000, 1);
        step(0, 5'b00000, 5'b00000, 1);
        step(0, 5'b00000, 5'b00000, 1);
        // round robin over 1,2,4 with credits returned every cycle
        step(1, 5'b00000, 5'b00000, 0);
        repeat (8) step(0, 5'b10110, 5'b11111, 1);
        // owner 2 starves while port 0 waits
        step(1, 5'b00000, 5'b00000, 0);
        step(0, 5'b00100, 5'b00000, 0);
        step(0, 5'b00001, 5'b00000, 0);
        step(0, 5'b00001, 5'b00000, 0);
        step(0, 5'b00101, 5'b00100, 0);
        step(0, 5'b00001, 5'b00000, 0);
        // overflow of credits sets the sticky error
        step(0, 5'b00000, 5'b00000, 1);
        step(0, 5'b00000, 5'b00000, 1);
        step(0, 5'b00000, 5'b00000, 0);
        // reset while locked on port 3, then all request
        step(1, 5'b00000, 5'b00000, 0);
        step(0, 5'b01000, 5'b00000, 0);
        step(0, 5'b01000, 5'b00000, 0);
        step(0, 5'b01000, 5'b00000, 0);
        step(1, 5'b01000, 5'b00000, 0);
        repeat (4) step(0, 5'b11111, 5'b00001, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, c;
            logic [N-1:0] q, t;
            r = ($urandom_range(99) == 0);
            q = N'($urandom);
            t = ($urandom_range(2) == 0) ? N'($urandom) : '0;
            c = ($urandom_range(1) == 0);
            step(r, q, t, c);
        end
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d left, 0 required", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
